// File: rtl/row_stage_pkg.sv
// Shared geometry, FSM state type and lane-mask helper for the row update stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package row_stage_pkg;

   localparam int NUM_MUL     = 4;
   localparam int DATA_WIDTH  = 64;
   localparam int INDEX_WIDTH = 12;
   localparam int ROW_W       = NUM_MUL * DATA_WIDTH;
   localparam int DEPTH       = 2 ** INDEX_WIDTH;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   // Replicate each lane-enable bit across its DATA_WIDTH-bit word.
   function automatic logic [ROW_W-1:0] lane_mask_expand(input logic [NUM_MUL-1:0] mask);
      logic [ROW_W-1:0] m;
      m = '0;
      for (int i = 0; i < NUM_MUL; i++) begin
         m[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{mask[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/row_nstage_xor_rmw_if.sv
// Write/lookup bus of the row update stage (NUM_WR write ports, one lookup port).
// Latency: n/a (signal bundle only).
// Backpressure: none; every port is fire-and-forget.
interface row_nstage_xor_rmw_if #(
   parameter int NUM_WR    = 8,
   parameter int KEY_WIDTH = 32,
   parameter int OPT_WIDTH = 2
);
   import row_stage_pkg::*;

   logic                           init_done;
   logic [NUM_WR-1:0]              wr_valid;
   logic [NUM_WR*NUM_MUL-1:0]      wr_lane_mask;
   logic [NUM_WR*INDEX_WIDTH-1:0]  wr_index;
   logic [NUM_WR*ROW_W-1:0]        wr_xor;
   logic                           rd_valid;
   logic [INDEX_WIDTH-1:0]         rd_index;
   logic [KEY_WIDTH-1:0]           rd_key;
   logic [OPT_WIDTH-1:0]           rd_opt;
   logic                           out_valid;
   logic [KEY_WIDTH-1:0]           out_key;
   logic [OPT_WIDTH-1:0]           out_opt;
   logic [NUM_WR*ROW_W-1:0]        out_data;

   modport master (
      output wr_valid, wr_lane_mask, wr_index, wr_xor,
      output rd_valid, rd_index, rd_key, rd_opt,
      input  init_done, out_valid, out_key, out_opt, out_data
   );

   modport slave (
      input  wr_valid, wr_lane_mask, wr_index, wr_xor,
      input  rd_valid, rd_index, rd_key, rd_opt,
      output init_done, out_valid, out_key, out_opt, out_data
   );

endinterface

// File: rtl/row_bank_rmw.sv
// One bank: row storage, 2-stage masked XOR read-modify-write with forwarding, read bypass.
// Latency: write commits at the end of cycle a+2; rd_row is combinational from rd_index.
// Backpressure: none; one write and one read per cycle always accepted.
module row_bank_rmw
   import row_stage_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clr_en,
   input  logic [INDEX_WIDTH-1:0] clr_index,
   input  logic                   wr_valid,
   input  logic [NUM_MUL-1:0]     wr_lane_mask,
   input  logic [INDEX_WIDTH-1:0] wr_index,
   input  logic [ROW_W-1:0]       wr_xor,
   input  logic [INDEX_WIDTH-1:0] rd_index,
   output logic [ROW_W-1:0]       rd_row
);

   logic [ROW_W-1:0]       mem [DEPTH];
   logic                   s1_valid;
   logic [INDEX_WIDTH-1:0] s1_index;
   logic [ROW_W-1:0]       s1_xor;
   logic [ROW_W-1:0]       s1_old;
   logic                   s2_valid;
   logic [INDEX_WIDTH-1:0] s2_index;
   logic [ROW_W-1:0]       s2_row;

   // Pipeline valids; reset kills any write still in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         s1_valid <= wr_valid;
         s2_valid <= s1_valid;
      end
   end

   // Pipeline payload: mask the operand on entry, form the new row in stage 1.
   always_ff @(posedge clk) begin
      s1_index <= wr_index;
      s1_xor   <= wr_xor & lane_mask_expand(wr_lane_mask);
      s2_index <= s1_index;
      s2_row   <= s1_old ^ s1_xor;
   end

   // Old row for stage 1: take the not-yet-committed row when the same index is ahead.
   always_comb begin
      s1_old = mem[s1_index];
      if (s2_valid && (s2_index == s1_index)) s1_old = s2_row;
   end

   // Storage write: clear sweep or RMW write-back, never during reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (clr_en) mem[clr_index] <= '0;
         else if (s2_valid) mem[s2_index] <= s2_row;
      end
   end

   // Lookup sees the row committing this cycle, but nothing still in stage 1.
   always_comb begin
      rd_row = mem[rd_index];
      if (s2_valid && (s2_index == rd_index)) rd_row = s2_row;
   end

endmodule

// File: rtl/row_nstage_xor_rmw.sv
// XOR-hash row update stage: NUM_WR RMW banks, shared lookup; ROW_STAGE_INIT_CLEAR_EN adds a clear sweep.
// Latency: lookup result RD_LAT cycles after rd_valid; writes visible to reads issued 2+ cycles later.
// Backpressure: none; inputs are dropped while init_done is low.
module row_nstage_xor_rmw
   import row_stage_pkg::*;
#(
   parameter int NUM_WR    = 8,
   parameter int KEY_WIDTH = 32,
   parameter int OPT_WIDTH = 2,
   parameter int RD_LAT    = 3
) (
   input logic                 clk,
   input logic                 reset,
   row_nstage_xor_rmw_if.slave bus
);

   state_t                   state;
   logic [INDEX_WIDTH-1:0]   ptr;
   logic                     init_done_q;
   logic                     clr_en;
   logic                     rd_go;
   logic [NUM_WR*ROW_W-1:0]  rd_row;

   logic [RD_LAT-1:0]        vld_pipe;
   logic [KEY_WIDTH-1:0]     key_pipe [RD_LAT-1];
   logic [OPT_WIDTH-1:0]     opt_pipe [RD_LAT-1];
   logic [NUM_WR*ROW_W-1:0]  dat_pipe [RD_LAT-1];
   logic [KEY_WIDTH-1:0]     out_key_q;
   logic [OPT_WIDTH-1:0]     out_opt_q;
   logic [NUM_WR*ROW_W-1:0]  out_data_q;

   // Init FSM: optional clear sweep over every row, then RUN with init_done high.
   always_ff @(posedge clk) begin
      if (reset) begin
`ifdef ROW_STAGE_INIT_CLEAR_EN
         state <= CLEAR;
`else
         state <= RUN;
`endif
         ptr         <= '0;
         init_done_q <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               ptr <= ptr + 1'b1;
               if (ptr == INDEX_WIDTH'(DEPTH - 1)) begin
                  state       <= RUN;
                  init_done_q <= 1'b1;
               end
            end
            default: init_done_q <= 1'b1;
         endcase
      end
   end

   assign clr_en = (state == CLEAR);
   assign rd_go  = bus.rd_valid & init_done_q;

   for (genvar i = 0; i < NUM_WR; i++) begin : g_bank
      row_bank_rmw u_bank (
         .clk          (clk),
         .reset        (reset),
         .clr_en       (clr_en),
         .clr_index    (ptr),
         .wr_valid     (bus.wr_valid[i] & init_done_q),
         .wr_lane_mask (bus.wr_lane_mask[i*NUM_MUL +: NUM_MUL]),
         .wr_index     (bus.wr_index[i*INDEX_WIDTH +: INDEX_WIDTH]),
         .wr_xor       (bus.wr_xor[i*ROW_W +: ROW_W]),
         .rd_index     (bus.rd_index),
         .rd_row       (rd_row[i*ROW_W +: ROW_W])
      );
   end

   // Lookup valid delay line; the last stage is out_valid.
   always_ff @(posedge clk) begin
      if (reset) vld_pipe <= '0;
      else vld_pipe <= {vld_pipe[RD_LAT-2:0], rd_go};
   end

   // Row and sideband travel together through the intermediate stages.
   always_ff @(posedge clk) begin
      key_pipe[0] <= bus.rd_key;
      opt_pipe[0] <= bus.rd_opt;
      dat_pipe[0] <= rd_row;
      for (int k = 1; k < RD_LAT - 1; k++) begin
         key_pipe[k] <= key_pipe[k-1];
         opt_pipe[k] <= opt_pipe[k-1];
         dat_pipe[k] <= dat_pipe[k-1];
      end
   end

   // Output registers load only with a valid result and hold otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_key_q  <= '0;
         out_opt_q  <= '0;
         out_data_q <= '0;
      end else if (vld_pipe[RD_LAT-2]) begin
         out_key_q  <= key_pipe[RD_LAT-2];
         out_opt_q  <= opt_pipe[RD_LAT-2];
         out_data_q <= dat_pipe[RD_LAT-2];
      end
   end

   assign bus.init_done = init_done_q;
   assign bus.out_valid = vld_pipe[RD_LAT-1];
   assign bus.out_key   = out_key_q;
   assign bus.out_opt   = out_opt_q;
   assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_row_nstage_xor_rmw.sv
// Directed bench for row_nstage_xor_rmw: one RD_LAT=3/8-bank instance and one RD_LAT=5/2-bank instance.
// Expectations follow ROW_STAGE_INIT_CLEAR_EN when the bench is built with it.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_row_nstage_xor_rmw;
   import row_stage_pkg::*;

   localparam int NW1 = 8;
   localparam int L1  = 3;
   localparam int NW2 = 2;
   localparam int L2  = 5;
   localparam int KW  = 32;
   localparam int OW  = 2;
`ifdef ROW_STAGE_INIT_CLEAR_EN
   localparam int INIT_CYC = DEPTH;
`else
   localparam int INIT_CYC = 1;
`endif

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   row_nstage_xor_rmw_if #(.NUM_WR(NW1), .KEY_WIDTH(KW), .OPT_WIDTH(OW)) bus1 ();
   row_nstage_xor_rmw_if #(.NUM_WR(NW2), .KEY_WIDTH(KW), .OPT_WIDTH(OW)) bus2 ();

   row_nstage_xor_rmw #(.NUM_WR(NW1), .KEY_WIDTH(KW), .OPT_WIDTH(OW), .RD_LAT(L1)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1.slave));
   row_nstage_xor_rmw #(.NUM_WR(NW2), .KEY_WIDTH(KW), .OPT_WIDTH(OW), .RD_LAT(L2)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2.slave));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus1.wr_valid = '0; bus1.wr_lane_mask = '0; bus1.wr_index = '0; bus1.wr_xor = '0;
      bus1.rd_valid = 1'b0; bus1.rd_index = '0; bus1.rd_key = '0; bus1.rd_opt = '0;
      bus2.wr_valid = '0; bus2.wr_lane_mask = '0; bus2.wr_index = '0; bus2.wr_xor = '0;
      bus2.rd_valid = 1'b0; bus2.rd_index = '0; bus2.rd_key = '0; bus2.rd_opt = '0;
   endtask

   task automatic set_wr(input int b, input logic [3:0] mask, input logic [11:0] idx,
                         input logic [63:0] l0, input logic [63:0] l1,
                         input logic [63:0] l2, input logic [63:0] l3);
      bus1.wr_valid[b] = 1'b1;
      bus1.wr_lane_mask[b*NUM_MUL +: NUM_MUL] = mask;
      bus1.wr_index[b*INDEX_WIDTH +: INDEX_WIDTH] = idx;
      bus1.wr_xor[b*ROW_W +: ROW_W] = {l3, l2, l1, l0};
   endtask

   // Issue a single lookup on dut1 and return what is presented RD_LAT cycles later.
   task automatic read1(input logic [11:0] idx, output logic [NW1*ROW_W-1:0] row, output logic vld);
      bus1.rd_valid = 1'b1;
      bus1.rd_index = idx;
      step();
      bus1.rd_valid = 1'b0;
      repeat (L1 - 1) step();
      vld = bus1.out_valid;
      row = bus1.out_data;
   endtask

   function automatic int diff_bank(input logic [NW1*ROW_W-1:0] a, input logic [NW1*ROW_W-1:0] b);
      for (int i = 0; i < NW1; i++) if (a[i*ROW_W +: ROW_W] !== b[i*ROW_W +: ROW_W]) return i;
      return 0;
   endfunction

   task automatic test_reset();
      int n;
      logic saw_out;
      reset = 1'b1;
      idle();
      step();
      step();
      checks++; if (bus1.init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", bus1.init_done); end
      checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus1.out_valid); end
      checks++; if (bus1.out_key !== '0) begin errors++; $display("FAIL reset_out_key: got %h want 0", bus1.out_key); end
      checks++; if (bus1.out_opt !== '0) begin errors++; $display("FAIL reset_out_opt: got %h want 0", bus1.out_opt); end
      checks++; if (bus1.out_data !== '0) begin errors++; $display("FAIL reset_out_data: nonzero after reset"); end
      reset = 1'b0;
      n = 0;
      saw_out = 1'b0;
      while (bus1.init_done !== 1'b1 && n < 10000) begin
`ifdef ROW_STAGE_INIT_CLEAR_EN
         if (n == 100) begin
            set_wr(3, 4'hF, 12'd100, '1, '1, '1, '1);
            bus1.rd_valid = 1'b1;
            bus1.rd_index = 12'd100;
         end else if (n == 101) begin
            idle();
         end
`endif
         step();
         n++;
         if (bus1.out_valid === 1'b1) saw_out = 1'b1;
      end
      idle();
      checks++; if (n !== INIT_CYC) begin errors++; $display("FAIL init_latency: got %0d cycles want %0d", n, INIT_CYC); end
      checks++; if (saw_out !== 1'b0) begin errors++; $display("FAIL init_rd_dropped: got out_valid during init want none"); end
      checks++; if (bus2.init_done !== 1'b1) begin errors++; $display("FAIL init_done_dut2: got %b want 1", bus2.init_done); end
   endtask

   task automatic test_zero_rows();
      logic [NW1*ROW_W-1:0] row;
      logic vld;
      logic [11:0] idx [3];
      idx[0] = 12'd0; idx[1] = 12'd4095; idx[2] = 12'd100;
      for (int i = 0; i < 3; i++) begin
         read1(idx[i], row, vld);
         checks++; if (vld !== 1'b1) begin errors++; $display("FAIL zero_row_valid idx %0d: got %b want 1", idx[i], vld); end
         checks++; if (row !== '0) begin errors++; $display("FAIL zero_row idx %0d: bank %0d got %h want 0", idx[i], diff_bank(row, '0), row[diff_bank(row, '0)*ROW_W +: ROW_W]); end
      end
   endtask

   task automatic test_masked_xor();
      logic [NW1*ROW_W-1:0] row;
      logic [NW1*ROW_W-1:0] exp;
      logic vld;
      int db;
      idle();
      set_wr(2, 4'b0101, 12'd5, 64'hA, 64'hB, 64'hC, 64'hD);
      step();
      idle();
      step();
      read1(12'd5, row, vld);
      exp = '0;
      exp[2*ROW_W +: 64]       = 64'hA;
      exp[2*ROW_W + 128 +: 64] = 64'hC;
      db = diff_bank(row, exp);
      checks++; if (vld !== 1'b1) begin errors++; $display("FAIL masked_valid: got %b want 1", vld); end
      checks++; if (row !== exp) begin errors++; $display("FAIL masked_xor: bank %0d got %h want %h", db, row[db*ROW_W +: ROW_W], exp[db*ROW_W +: ROW_W]); end
   endtask

   task automatic test_back_to_back();
      logic [NW1*ROW_W-1:0] row;
      logic [NW1*ROW_W-1:0] exp;
      logic vld;
      int db;
      idle();
      set_wr(0, 4'hF, 12'd7, 64'h1, 64'h0, 64'h0, 64'h0);
      set_wr(4, 4'hF, 12'd7, 64'h80, 64'h0, 64'h0, 64'h0);
      step(); idle();
      set_wr(0, 4'hF, 12'd7, 64'h2, 64'h0, 64'h0, 64'h0);
      step(); idle();
      set_wr(0, 4'h0, 12'd7, '1, '1, '1, '1);
      step(); idle();
      set_wr(0, 4'hF, 12'd7, 64'h4, 64'h0, 64'h0, 64'h0);
      step(); idle();
      step();
      step();
      read1(12'd7, row, vld);
      exp = '0;
      exp[0 +: 64]       = 64'h7;
      exp[4*ROW_W +: 64] = 64'h80;
      db = diff_bank(row, exp);
      checks++; if (row[0 +: 64] !== 64'h7) begin errors++; $display("FAIL b2b_accumulate: got %h want 7", row[0 +: 64]); end
      checks++; if (row !== exp) begin errors++; $display("FAIL b2b_row: bank %0d got %h want %h", db, row[db*ROW_W +: ROW_W], exp[db*ROW_W +: ROW_W]); end
   endtask

   task automatic test_visibility();
      logic [63:0] exp_l [3];
      exp_l[0] = 64'h0; exp_l[1] = 64'h0; exp_l[2] = 64'hFF;
      idle();
      set_wr(1, 4'hF, 12'd9, 64'hFF, 64'h0, 64'h0, 64'h0);
      bus1.rd_valid = 1'b1; bus1.rd_index = 12'd9;
      step();
      bus1.wr_valid = '0;
      step();
      step();
      idle();
      repeat (L1 - 3) step();
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus1.out_valid !== 1'b1) begin errors++; $display("FAIL vis_valid a+%0d: got %b want 1", i, bus1.out_valid); end
         checks++; if (bus1.out_data[ROW_W +: 64] !== exp_l[i]) begin errors++; $display("FAIL vis_lane0 a+%0d: got %h want %h", i, bus1.out_data[ROW_W +: 64], exp_l[i]); end
         step();
      end
   endtask

   task automatic test_sideband();
      logic e1, e2;
      logic [KW-1:0] ek;
      logic [OW-1:0] eo;
      idle();
      bus1.rd_valid = 1'b1; bus1.rd_key = 32'h1234; bus1.rd_opt = 2'd2;
      bus2.rd_valid = 1'b1; bus2.rd_key = 32'h1234; bus2.rd_opt = 2'd2;
      step();
      bus1.rd_key = 32'h5678; bus1.rd_opt = 2'd1;
      bus2.rd_key = 32'h5678; bus2.rd_opt = 2'd1;
      step();
      idle();
      for (int k = 2; k <= 8; k++) begin
         e1 = (k == L1) || (k == L1 + 1);
         e2 = (k == L2) || (k == L2 + 1);
         checks++; if (bus1.out_valid !== e1) begin errors++; $display("FAIL sb_valid1 t+%0d: got %b want %b", k, bus1.out_valid, e1); end
         checks++; if (bus2.out_valid !== e2) begin errors++; $display("FAIL sb_valid2 t+%0d: got %b want %b", k, bus2.out_valid, e2); end
         if (k == L1 || k == L2) begin ek = 32'h1234; eo = 2'd2; end
         else begin ek = 32'h5678; eo = 2'd1; end
         if (e1) begin
            checks++; if (bus1.out_key !== ek || bus1.out_opt !== eo) begin errors++; $display("FAIL sb_key1 t+%0d: got %h/%0d want %h/%0d", k, bus1.out_key, bus1.out_opt, ek, eo); end
         end
         if (e2) begin
            checks++; if (bus2.out_key !== ek || bus2.out_opt !== eo) begin errors++; $display("FAIL sb_key2 t+%0d: got %h/%0d want %h/%0d", k, bus2.out_key, bus2.out_opt, ek, eo); end
            checks++; if (bus2.out_data !== '0) begin errors++; $display("FAIL sb_data2 t+%0d: nonzero row for index 0", k); end
         end
         step();
      end
      checks++; if (bus1.out_key !== 32'h5678 || bus1.out_opt !== 2'd1) begin errors++; $display("FAIL sb_hold1: got %h/%0d want 5678/1", bus1.out_key, bus1.out_opt); end
      checks++; if (bus2.out_key !== 32'h5678 || bus2.out_opt !== 2'd1) begin errors++; $display("FAIL sb_hold2: got %h/%0d want 5678/1", bus2.out_key, bus2.out_opt); end
   endtask

   task automatic test_reset_midop();
      logic [NW1*ROW_W-1:0] row;
      logic [NW1*ROW_W-1:0] exp;
      logic vld;
      int n;
      int db;
      idle();
      set_wr(0, 4'hF, 12'd7, 64'h100, 64'h0, 64'h0, 64'h0);
      bus1.rd_valid = 1'b1; bus1.rd_index = 12'd7;
      step();
      idle();
      set_wr(0, 4'hF, 12'd7, 64'h200, 64'h0, 64'h0, 64'h0);
      reset = 1'b1;
      step();
      idle();
      reset = 1'b0;
      checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid a+2: got %b want 0", bus1.out_valid); end
      checks++; if (bus1.init_done !== 1'b0) begin errors++; $display("FAIL midrst_init_done: got %b want 0", bus1.init_done); end
      step();
      n = 1;
      checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid a+3: got %b want 0", bus1.out_valid); end
      while (bus1.init_done !== 1'b1 && n < 10000) begin
         step();
         n++;
      end
      checks++; if (n !== INIT_CYC) begin errors++; $display("FAIL midrst_init_latency: got %0d cycles want %0d", n, INIT_CYC); end
      read1(12'd7, row, vld);
      exp = '0;
`ifndef ROW_STAGE_INIT_CLEAR_EN
      exp[0 +: 64]       = 64'h7;
      exp[4*ROW_W +: 64] = 64'h80;
`endif
      db = diff_bank(row, exp);
      checks++; if (row !== exp) begin errors++; $display("FAIL midrst_row: bank %0d got %h want %h", db, row[db*ROW_W +: ROW_W], exp[db*ROW_W +: ROW_W]); end
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_zero_rows();
      test_masked_xor();
      test_back_to_back();
      test_visibility();
      test_sideband();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
